// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: latches a reply request, acknowledges it, and serialises a
// zero-padded Ethernet ARP reply frame onto an 8-bit AXI-stream.
//   state | meaning
//   IDLE  | waiting for arp_reply_in
//   SEND  | streaming frame bytes 0..FRAME_LEN-1
//   GAP   | enforced idle cycles after tlast
module arp_reply_tx #(
    parameter int FRAME_LEN  = 60,
    parameter int GAP_CYCLES = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] local_mac_addr,
    input  logic [31:0] local_ip_addr,
    input  logic        arp_reply_in,
    input  logic [47:0] remote_mac_addr_in,
    input  logic [31:0] remote_ip_addr_in,
    output logic        arp_reply_ack_out,
    output logic        reply_ready_out,
    output logic [7:0]  axis_tdata_out,
    output logic        axis_tvalid_out,
    output logic        axis_tlast_out,
    input  logic        axis_tready_in,
    output logic [15:0] frames_sent_out
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    state_t      state;
    logic [6:0]  cnt;
    logic [7:0]  gap_cnt;
    logic [15:0] frame_count;
    logic        ack;
    logic        tvalid;
    logic [47:0] lat_rmac;
    logic [31:0] lat_rip;
    logic [47:0] lat_lmac;
    logic [31:0] lat_lip;
    logic [41:0][7:0] hdr;
    logic [7:0]  byte_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 7'd0;
            gap_cnt     <= 8'd0;
            frame_count <= 16'd0;
            ack         <= 1'b0;
            tvalid      <= 1'b0;
            lat_rmac    <= 48'd0;
            lat_rip     <= 32'd0;
            lat_lmac    <= 48'd0;
            lat_lip     <= 32'd0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (arp_reply_in) begin
                        lat_rmac <= remote_mac_addr_in;
                        lat_rip  <= remote_ip_addr_in;
                        lat_lmac <= local_mac_addr;
                        lat_lip  <= local_ip_addr;
                        cnt      <= 7'd0;
                        ack      <= 1'b1;
                        tvalid   <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (axis_tready_in) begin
                        if (cnt == LAST_IDX) begin
                            tvalid      <= 1'b0;
                            cnt         <= 7'd0;
                            frame_count <= frame_count + 16'd1;
                            if (GAP_LOAD == 8'd0) begin
                                state <= IDLE;
                            end else begin
                                gap_cnt <= GAP_LOAD;
                                state   <= GAP;
                            end
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end
                GAP: begin
                    // leaving on the last count keeps occupancy at FRAME_LEN+GAP_CYCLES+1
                    if (gap_cnt <= 8'd1) begin
                        gap_cnt <= 8'd0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // element 41 is the first byte on the wire
    assign hdr = {lat_rmac, lat_lmac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                  16'h0002, lat_lmac, lat_lip, lat_rmac, lat_rip};

    always_comb begin
        byte_val = 8'h00;
        if (tvalid && (cnt < 7'd42)) begin
            byte_val = hdr[6'd41 - cnt[5:0]];
        end
    end

    assign arp_reply_ack_out = ack;
    assign reply_ready_out   = (state == IDLE);
    assign axis_tdata_out    = byte_val;
    assign axis_tvalid_out   = tvalid;
    assign axis_tlast_out    = tvalid && (cnt == LAST_IDX);
    assign frames_sent_out   = frame_count;

endmodule

// File: doc/arp_reply_tx.md
Name: arp_reply_tx

Overview:
- Transmit-side ARP responder, directly downstream of the receive path's ARP reply request (arp_reply_out, remote_ip_addr_out, remote_mac_addr_out).
- On each request it latches the requester's addresses and returns a one-cycle acknowledge.
- It then serialises a complete Ethernet ARP reply frame, zero-padded, onto an 8-bit AXI-stream toward the MAC TX arbiter.
- Runs entirely in the 8-bit (clk_8) domain.

Parameters:
- FRAME_LEN, 60, total bytes emitted per frame (legal 42..64); bytes 42..FRAME_LEN-1 are 8'h00.
- GAP_CYCLES, 12, idle cycles forced after tlast before the next request is sampled (legal 0..255).

Ports:
- clk  input  1  clock (clk_8 domain).
- reset  input  1  asynchronous, active-high reset.
- local_mac_addr  input  48  own MAC; sampled at request latch.
- local_ip_addr  input  32  own IP; sampled at request latch.
- arp_reply_in  input  1  level request from the ARP receiver.
- remote_mac_addr_in  input  48  requester MAC; valid while arp_reply_in=1.
- remote_ip_addr_in  input  32  requester IP; valid while arp_reply_in=1.
- arp_reply_ack_out  output  1  one-cycle pulse: request latched.
- reply_ready_out  output  1  1 when in IDLE and able to accept a request.
- axis_tdata_out  output  8  frame byte.
- axis_tvalid_out  output  1  byte valid.
- axis_tlast_out  output  1  final byte of frame.
- axis_tready_in  input  1  downstream ready.
- frames_sent_out  output  16  count of completed frames; wraps 16'hFFFF->0.

Behaviour:
- Reset: all outputs 0 except reply_ready_out=1; state IDLE; byte counter, gap counter and latched addresses cleared.
- States: IDLE, SEND, GAP.
- reply_ready_out = (state==IDLE), combinational.
- IDLE:
  - If arp_reply_in=1 at edge N: latch remote MAC/IP and local MAC/IP, set byte counter=0.
  - At N+1: arp_reply_ack_out=1 (exactly one cycle), state=SEND, tvalid=1 with byte 0.
- SEND:
  - axis_tdata_out = byte[cnt] from the latched registers, big-endian, MSB byte first.
  - Byte layout:
    - 0-5: remote MAC
    - 6-11: local MAC
    - 12-13: 08 06
    - 14-15: 00 01
    - 16-17: 08 00
    - 18: 06
    - 19: 04
    - 20-21: 00 02
    - 22-27: local MAC
    - 28-31: local IP
    - 32-37: remote MAC
    - 38-41: remote IP
    - 42..FRAME_LEN-1: 00
  - cnt advances only on tvalid&tready.
  - tdata, tvalid and tlast are held stable while tready=0.
  - tlast=1 exactly when cnt==FRAME_LEN-1.
  - On the tlast handshake: tvalid->0 next cycle, frames_sent++ (wrap), gap counter loaded with GAP_CYCLES, state=GAP. If GAP_CYCLES=0, go directly to IDLE.
- GAP: decrement each cycle; at 0 go to IDLE. arp_reply_in is ignored in SEND and GAP.
- Request protocol:
  - Upstream must deassert arp_reply_in on the cycle after the ack.
  - A request still high on return to IDLE is treated as a new request (another frame, another ack).
  - Address inputs are not used after the latch; changes during SEND do not affect the frame.
- Output stream: no bubbles inside a frame other than tready stalls. Minimum per-frame occupancy is FRAME_LEN+GAP_CYCLES+1 cycles.
- Reset mid-frame: tvalid and tlast drop asynchronously; the partial frame is abandoned with no tlast; the counter is not incremented; block returns to IDLE.
- tready=1 while tvalid=0 has no effect.

Test Plan:
- Basic frame, default params:
  - Stimulus: local MAC 00:0A:35:01:02:03, IP C0A80001; remote MAC 11:22:33:44:55:66, IP C0A80064; one-cycle request; tready=1.
  - Required: ack 1 cycle after request; 60 consecutive bytes starting 11 22 33 44 55 66 00 0A 35 01 02 03 08 06 00 01 08 00 06 04 00 02; byte 41=64; bytes 42-59 = 00; tlast only on byte 59; frames_sent=1.
- Backpressure:
  - Stimulus: toggle tready 1,0,0,1 repeatedly.
  - Required: data identical to the basic test; tdata/tvalid/tlast stable during every stall; tlast still on the 60th accepted byte.
- Busy request:
  - Stimulus: pulse arp_reply_in mid-SEND and again mid-GAP.
  - Required: no ack, frame unchanged, reply_ready_out=0 throughout.
- Held request:
  - Stimulus: hold arp_reply_in high for 200 cycles with GAP_CYCLES=12.
  - Required: back-to-back frames; each next ack exactly 13 cycles after the previous tlast handshake; frames_sent increments per frame.
- Reset mid-frame:
  - Stimulus: assert reset after byte 20 is accepted.
  - Required: tvalid=0 immediately; no tlast; frames_sent=0; reply_ready_out=1; next request produces a complete, correct frame.
- Parameter and wrap:
  - Stimulus: FRAME_LEN=42, GAP_CYCLES=0; preload via 65536 frames (or force counter to FFFF).
  - Required: tlast on byte 41 (remote IP LSB); IDLE the cycle after tlast; counter wraps FFFF->0000.
